// File: rtl/button_toggle_debouncer.sv
// rtl/button_toggle_debouncer.sv - pushbutton synchroniser, debouncer and press/release/long-press pulse generator
//
// Purpose: takes a raw, bouncing, asynchronous button input, synchronises it into
// clk_in, qualifies every level change with N stable samples, and emits one-cycle
// pulses on debounced press, release and long-press.
//
// Ports:
//   clk_in            - system clock
//   rst_in            - asynchronous active-high reset
//   btn_in            - raw button, asynchronous to clk_in, may bounce
//   btn_level_out     - debounced level, 1 = pressed
//   press_pulse_out   - one-cycle pulse on each debounced press
//   release_pulse_out - one-cycle pulse on each debounced release
//   long_press_out    - one-cycle pulse, at most once per press, after L cycles held
module button_toggle_debouncer #(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int DEBOUNCE_US   = 10_000,
  parameter int LONG_PRESS_MS = 1000,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_in,
  output logic btn_level_out,
  output logic press_pulse_out,
  output logic release_pulse_out,
  output logic long_press_out
);

  localparam int N  = CLK_FREQ_HZ / 1_000_000 * DEBOUNCE_US;
  localparam int L  = CLK_FREQ_HZ / 1000 * LONG_PRESS_MS;
  localparam int CW = $clog2(N + 1);
  localparam int HW = $clog2(L + 1);

  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [HW-1:0] H_LAST = HW'(L - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(L);

  generate
    if (N < 2) begin : g_bad_debounce
      $error("button_toggle_debouncer: debounce length N must be at least 2 cycles");
    end
    if (L < 1) begin : g_bad_long_press
      $error("button_toggle_debouncer: long-press length L must be at least 1 cycle");
    end
  endgenerate

  typedef enum logic [1:0] {
    RELEASED,
    ARMING_PRESS,
    PRESSED,
    ARMING_RELEASE
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic [HW-1:0] r_hold;
  logic          r_long_done;

  // Polarity is normalised before the synchroniser so everything downstream
  // treats 1 as pressed.
  logic w_btn;
  assign w_btn = btn_in ^ ACTIVE_LOW;

  // The hold timer runs while the button is logically held, including while a
  // release is being qualified. On the edge that completes a release it stops,
  // so a long-press pulse can never coincide with the release pulse.
  logic w_release_done;
  logic w_hold_active;
  assign w_release_done = (r_state == ARMING_RELEASE) && !r_sync2 && (r_cnt == C_LAST);
  assign w_hold_active  = ((r_state == PRESSED) || (r_state == ARMING_RELEASE)) && !w_release_done;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sync1           <= 1'b0;
      r_sync2           <= 1'b0;
      r_cnt             <= '0;
      r_hold            <= '0;
      r_long_done       <= 1'b0;
      r_state           <= RELEASED;
      btn_level_out     <= 1'b0;
      press_pulse_out   <= 1'b0;
      release_pulse_out <= 1'b0;
      long_press_out    <= 1'b0;
    end else begin
      r_sync1           <= w_btn;
      r_sync2           <= r_sync1;
      press_pulse_out   <= 1'b0;
      release_pulse_out <= 1'b0;
      long_press_out    <= 1'b0;

      case (r_state)
        RELEASED: begin
          btn_level_out <= 1'b0;
          if (r_sync2) begin
            r_cnt   <= CW'(1);
            r_state <= ARMING_PRESS;
          end
        end
        ARMING_PRESS: begin
          if (!r_sync2) begin
            r_cnt   <= '0;
            r_state <= RELEASED;
          end else if (r_cnt == C_LAST) begin
            btn_level_out   <= 1'b1;
            press_pulse_out <= 1'b1;
            r_cnt           <= '0;
            r_hold          <= '0;
            r_long_done     <= 1'b0;
            r_state         <= PRESSED;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        PRESSED: begin
          btn_level_out <= 1'b1;
          if (!r_sync2) begin
            r_cnt   <= CW'(1);
            r_state <= ARMING_RELEASE;
          end
        end
        ARMING_RELEASE: begin
          if (r_sync2) begin
            r_cnt   <= '0;
            r_state <= PRESSED;
          end else if (r_cnt == C_LAST) begin
            btn_level_out     <= 1'b0;
            release_pulse_out <= 1'b1;
            r_cnt             <= '0;
            r_state           <= RELEASED;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= RELEASED;
        end
      endcase

      // Saturating hold timer; long_done limits the long-press pulse to once per press.
      if (w_hold_active) begin
        if (r_hold != H_MAX) begin
          r_hold <= r_hold + HW'(1);
        end
        if ((r_hold == H_LAST) && !r_long_done) begin
          long_press_out <= 1'b1;
          r_long_done    <= 1'b1;
        end
      end
    end
  end

endmodule
